// File: rtl/vec_pair_loader_pkg.sv
// Shared widths, limits and FSM encoding for the vector pair loader.
package vec_pair_loader_pkg;
  localparam int WIDTH     = 32;
  localparam int LEN_WIDTH = 6;
  localparam int MAX_LEN   = 32;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_DONE} state_t;

  // A header length is usable only when it names a non-empty vector that fits.
  function automatic logic hdr_legal(input logic [LEN_WIDTH-1:0] h);
    return (h != '0) && (h <= LEN_WIDTH'(MAX_LEN));
  endfunction
endpackage

// File: rtl/vec_pair_loader_if.sv
// Packet input stream plus the two vector output streams of the loader.
interface vec_pair_loader_if;
  import vec_pair_loader_pkg::*;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  // master: packet source and vector sinks; slave: the loader itself
  modport master (
    output in_data, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
  );
  modport slave (
    input  in_data, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
  );
endinterface

// File: rtl/vec_pair_loader_skid.sv
// Two-entry skid buffer with registered outputs; full depends on state only.
module vec_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] head_q, skid_q;
  logic             head_vld, skid_vld;
  logic             do_push, do_pop;

  assign do_push   = push && !skid_vld;
  assign do_pop    = head_vld && out_ready;
  assign full      = skid_vld;
  assign out_data  = head_q;
  assign out_valid = head_vld;

  // Head is the visible word; skid catches a push while head is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (do_pop) begin
      if (skid_vld) begin
        head_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (do_push) begin
        head_q <= push_data;
      end else begin
        head_vld <= 1'b0;
      end
    end else if (do_push) begin
      if (!head_vld) begin
        head_q   <= push_data;
        head_vld <= 1'b1;
      end else begin
        skid_q   <= push_data;
        skid_vld <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/vec_pair_loader.sv
// Splits a header+a-words+b-words packet into two buffered vector streams.
module vec_pair_loader
  import vec_pair_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  vec_pair_loader_if.slave     bus,
  input  logic                 done,
  output logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 err_hdr
);
  state_t               state;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 a_full, b_full;
  logic                 in_ready_c, in_fire, a_push, b_push, last_word;

  assign hdr_len   = bus.in_data[LEN_WIDTH-1:0];
  assign last_word = (cnt + LEN_WIDTH'(1)) == len;

  // Ready comes only from state and registered buffer occupancy.
  always_comb begin
    in_ready_c = 1'b0;
    case (state)
      IDLE:    in_ready_c = 1'b1;
      SEND_A:  in_ready_c = !a_full;
      SEND_B:  in_ready_c = !b_full;
      default: in_ready_c = 1'b0;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign in_fire      = bus.in_valid && in_ready_c;
  assign a_push       = in_fire && (state == SEND_A);
  assign b_push       = in_fire && (state == SEND_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len     <= '0;
      busy    <= 1'b0;
      err_hdr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          if (hdr_legal(hdr_len)) begin
            len   <= hdr_len;
            cnt   <= '0;
            state <= SEND_A;
            busy  <= 1'b1;
          end else begin
            err_hdr <= 1'b1;
          end
        end
        SEND_A: if (in_fire) begin
          if (last_word) begin
            cnt   <= '0;
            state <= SEND_B;
          end else begin
            cnt <= cnt + LEN_WIDTH'(1);
          end
        end
        SEND_B: if (in_fire) begin
          if (last_word) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt + LEN_WIDTH'(1);
          end
        end
        WAIT_DONE: if (done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  vec_skid_buf #(.WIDTH(WIDTH)) u_a_buf (
    .clk       (clk),
    .rst       (rst),
    .push_data (bus.in_data),
    .push      (a_push),
    .full      (a_full),
    .out_data  (bus.a_data),
    .out_valid (bus.a_valid),
    .out_ready (bus.a_ready)
  );

  vec_skid_buf #(.WIDTH(WIDTH)) u_b_buf (
    .clk       (clk),
    .rst       (rst),
    .push_data (bus.in_data),
    .push      (b_push),
    .full      (b_full),
    .out_data  (bus.b_data),
    .out_valid (bus.b_valid),
    .out_ready (bus.b_ready)
  );
endmodule

// File: tb/tb_vec_pair_loader.sv
// Directed bench: header table loop plus hand sequences for stalls, reset and done.
module tb_vec_pair_loader;
  import vec_pair_loader_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 done = 1'b0;
  logic [LEN_WIDTH-1:0] len;
  logic                 busy, err_hdr;
  int                   sink_mode = 0;  // 0 ready high, 1 random, 2 ready low

  vec_pair_loader_if bus();

  vec_pair_loader dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .done    (done),
    .len     (len),
    .busy    (busy),
    .err_hdr (err_hdr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] a_got[$], b_got[$];
  logic [WIDTH-1:0] a_exp[$], b_exp[$];
  int a_rd = 0, b_rd = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.a_valid && bus.a_ready) a_got.push_back(bus.a_data);
      if (bus.b_valid && bus.b_ready) b_got.push_back(bus.b_data);
    end
  end

  always @(negedge clk) begin
    case (sink_mode)
      0: begin bus.a_ready = 1'b1; bus.b_ready = 1'b1; end
      1: begin bus.a_ready = 1'($urandom_range(0, 1)); bus.b_ready = 1'($urandom_range(0, 1)); end
      default: begin bus.a_ready = 1'b0; bus.b_ready = 1'b0; end
    endcase
  end

  typedef struct {
    logic [31:0]          hdr;
    logic                 legal;
    logic                 exp_err;
    logic [LEN_WIDTH-1:0] exp_len;
    int                   mode;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [WIDTH-1:0] mk(input int k, input int i);
    return WIDTH'((k << 16) | (i + 1));
  endfunction

  // Called just after a rising edge; returns just after the edge that took the word.
  task automatic send_word(input logic [WIDTH-1:0] d, output int stalls);
    int guard = 0;
    stalls = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    forever begin
      if (bus.in_ready) begin
        step();
        break;
      end
      stalls++;
      guard++;
      if (guard > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: word %0h never accepted, required acceptance", d);
        break;
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_compare();
    int g = 0;
    while (((a_got.size() - a_rd) < a_exp.size() || (b_got.size() - b_rd) < b_exp.size()) && g < 500) begin
      step();
      g++;
    end
    chk("drain_a_count", 64'(a_got.size() - a_rd), 64'(a_exp.size()));
    chk("drain_b_count", 64'(b_got.size() - b_rd), 64'(b_exp.size()));
    foreach (a_exp[i]) chk("a_word", (a_rd + i < a_got.size()) ? 64'(a_got[a_rd + i]) : 64'hdead, 64'(a_exp[i]));
    foreach (b_exp[i]) chk("b_word", (b_rd + i < b_got.size()) ? 64'(b_got[b_rd + i]) : 64'hdead, 64'(b_exp[i]));
    a_rd = a_got.size();
    b_rd = b_got.size();
    a_exp.delete();
    b_exp.delete();
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic finish_pkt(input int stall_total, input logic chk_stall);
    chk("wait_busy", busy, 1);
    chk("wait_in_ready", bus.in_ready, 0);
    if (chk_stall) chk("stream_stalls", 64'(stall_total), 0);
    drain_compare();
    chk("wait_busy_drained", busy, 1);
    pulse_done();
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_body(input int k, input int n, input logic chk_stall);
    int st;
    int tot = 0;
    a_exp.delete();
    b_exp.delete();
    for (int i = 0; i < n; i++) begin a_exp.push_back(mk(k, i));     send_word(mk(k, i), st);     tot += st; end
    for (int i = 0; i < n; i++) begin b_exp.push_back(mk(k, n + i)); send_word(mk(k, n + i), st); tot += st; end
    finish_pkt(tot, chk_stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int st;
    tbl[0] = '{32'd3,          1'b1, 1'b0, 6'd3,  0};
    tbl[1] = '{32'd0,          1'b0, 1'b1, 6'd3,  0};
    tbl[2] = '{32'd33,         1'b0, 1'b1, 6'd3,  0};
    tbl[3] = '{32'd2,          1'b1, 1'b1, 6'd2,  1};
    tbl[4] = '{32'd32,         1'b1, 1'b1, 6'd32, 0};
    tbl[5] = '{32'hFFFF_FFC1,  1'b1, 1'b1, 6'd1,  0};
    tbl[6] = '{32'h0000_0040,  1'b0, 1'b1, 6'd1,  0};
    tbl[7] = '{32'd63,         1'b0, 1'b1, 6'd1,  0};
    tbl[8] = '{32'd31,         1'b1, 1'b1, 6'd31, 1};

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_err", err_hdr, 0);
    chk("rst_len", len, 0);
    chk("rst_a_valid", bus.a_valid, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    rst = 1'b0;
    chk("post_rst_in_ready", bus.in_ready, 1);
    step();

    for (int k = 0; k < 9; k++) begin
      sink_mode = tbl[k].mode;
      send_word(tbl[k].hdr, st);
      chk("hdr_err", err_hdr, tbl[k].exp_err);
      chk("hdr_len", len, tbl[k].exp_len);
      chk("hdr_busy", busy, tbl[k].legal);
      if (tbl[k].legal) run_body(k, int'(tbl[k].exp_len), tbl[k].mode == 0);
    end

    // a-side backpressure: buffer holds two words then input stalls
    sink_mode = 2;
    step();
    send_word(32'd4, st);
    chk("bp_len", len, 4);
    for (int i = 0; i < 4; i++) a_exp.push_back(mk(20, i));
    for (int i = 0; i < 4; i++) b_exp.push_back(mk(20, 4 + i));
    send_word(mk(20, 0), st);
    chk("bp_first_visible", bus.a_data, mk(20, 0));
    send_word(mk(20, 1), st);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_a_valid", bus.a_valid, 1);
    repeat (3) step();
    chk("bp_a_hold", bus.a_data, mk(20, 0));
    chk("bp_still_low", bus.in_ready, 0);
    sink_mode = 0;
    send_word(mk(20, 2), st);
    send_word(mk(20, 3), st);
    for (int i = 0; i < 4; i++) send_word(mk(20, 4 + i), st);
    finish_pkt(0, 1'b0);

    // reset in the middle of the a-words
    sink_mode = 2;
    step();
    send_word(32'd5, st);
    send_word(mk(25, 0), st);
    send_word(mk(25, 1), st);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_hdr, 0);
    chk("mid_rst_len", len, 0);
    chk("mid_rst_a_valid", bus.a_valid, 0);
    chk("mid_rst_b_valid", bus.b_valid, 0);
    chk("mid_rst_state", dut.state, IDLE);
    rst = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    sink_mode = 0;
    send_word(32'd1, st);
    chk("mid_rst_new_len", len, 1);
    run_body(30, 1, 1'b1);

    // done ignored in SEND_B, honoured in WAIT_DONE; held header waits for it
    send_word(32'd2, st);
    for (int i = 0; i < 2; i++) a_exp.push_back(mk(40, i));
    for (int i = 0; i < 2; i++) b_exp.push_back(mk(40, 2 + i));
    send_word(mk(40, 0), st);
    send_word(mk(40, 1), st);
    send_word(mk(40, 2), st);
    chk("sb_state", dut.state, SEND_B);
    pulse_done();
    chk("sb_done_ignored", dut.state, SEND_B);
    chk("sb_busy", busy, 1);
    send_word(mk(40, 3), st);
    chk("wd_state", dut.state, WAIT_DONE);
    drain_compare();
    bus.in_data  = 32'd1;
    bus.in_valid = 1'b1;
    repeat (2) step();
    chk("wd_hdr_blocked_busy", busy, 1);
    chk("wd_hdr_blocked_len", len, 2);
    pulse_done();
    chk("wd_exit_busy", busy, 0);
    chk("wd_exit_len_kept", len, 2);
    chk("wd_exit_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("next_hdr_busy", busy, 1);
    chk("next_hdr_len", len, 1);
    run_body(41, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
